// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one TX FIFO push port, with stall watchdog.
// Optional UART_ARB_PRIO_EN gives requester 0 priority at each arbitration.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  output logic                          tx_wr_en_o,
  input  logic                          tx_full_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic [ID_WIDTH-1:0]           timeout_id_o
);
  localparam int CW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [ID_WIDTH-1:0] gidx, gidx_n, last_grant, last_n, sel, idx, toid_n;
  logic [CW-1:0] cnt, cnt_n;
  logic to_n, found;
  assign busy_o  = state == GRANT;
  assign grant_o = busy_o ? NUM_REQ'(1) << gidx : '0;
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_WIDTH'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
`ifdef UART_ARB_PRIO_EN
    if (req_valid[0]) sel = '0;
`endif
  end
  // A transfer clears the watchdog before any expiry check, so it always wins.
  always_comb begin
    state_n    = state;
    gidx_n     = gidx;
    last_n     = last_grant;
    cnt_n      = cnt;
    to_n       = 1'b0;
    toid_n     = timeout_id_o;
    req_ready  = '0;
    tx_wr_en_o = 1'b0;
    tx_data_o  = '0;
    if (state == IDLE) begin
      if (|req_valid) begin
        state_n = GRANT;
        gidx_n  = sel;
        cnt_n   = '0;
      end
    end else begin
      req_ready[gidx] = ~tx_full_i;
      tx_wr_en_o      = req_valid[gidx] & ~tx_full_i;
      tx_data_o       = tx_wr_en_o ? req_data[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (tx_wr_en_o) begin
        cnt_n = '0;
        if (req_last[gidx]) begin
          state_n = IDLE;
          last_n  = gidx;
        end
      end else if (TIMEOUT > 0 && !req_valid[gidx]) begin
        if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          last_n  = gidx;
          to_n    = 1'b1;
          toid_n  = gidx;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state        <= IDLE;
      gidx         <= '0;
      last_grant   <= ID_WIDTH'(NUM_REQ - 1);
      cnt          <= '0;
      timeout_o    <= 1'b0;
      timeout_id_o <= '0;
    end else begin
      state        <= state_n;
      gidx         <= gidx_n;
      last_grant   <= last_n;
      cnt          <= cnt_n;
      timeout_o    <= to_n;
      timeout_id_o <= toid_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: queue-fed requesters checked each cycle against an ownership-level reference model.
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, TO = 8, IW = 2;
  logic sys_clk = 1'b0;
  logic reset, tx_full_i, tx_wr_en_o, busy_o, timeout_o;
  logic [N-1:0] req_valid, req_last, req_ready, grant_o;
  logic [N*W-1:0] req_data;
  logic [W-1:0] tx_data_o;
  logic [IW-1:0] timeout_id_o;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] qd[N][$];
  bit ql[N][$];
  bit stall[N];
  bit full;
  int owner = -1, lastg = N - 1, idle = 0, to_p = 0, to_id = 0;
  int pushes = 0, tos = 0;
  logic [N-1:0] exp_g;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT(TO), .ID_WIDTH(IW)) dut (
    .sys_clk(sys_clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data_o(tx_data_o),
    .tx_wr_en_o(tx_wr_en_o), .tx_full_i(tx_full_i), .grant_o(grant_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .timeout_id_o(timeout_id_o));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input int r, input int len, input logic [W-1:0] b0);
    for (int k = 0; k < len; k++) begin
      qd[r].push_back(b0 + W'(k));
      ql[r].push_back(k == len - 1);
    end
  endtask

  task automatic cycle(input bit rst);
    bit x, l;
    int pick;
    @(negedge sys_clk);
    reset = rst;
    tx_full_i = full;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = qd[i].size() > 0 && !stall[i];
      req_last[i] = qd[i].size() > 0 ? ql[i][0] : 1'($urandom);
      req_data[i*W +: W] = qd[i].size() > 0 ? qd[i][0] : W'($urandom);
    end
    #1;
    x = owner >= 0 && req_valid[owner] && !full;
    check("grant", grant_o, owner >= 0 ? 1 << owner : 0);
    check("busy", busy_o, owner >= 0);
    check("ready", req_ready, (owner >= 0 && !full) ? 1 << owner : 0);
    check("wr_en", tx_wr_en_o, x);
    check("data", tx_data_o, x ? qd[owner][0] : 0);
    check("timeout", timeout_o, to_p);
    check("timeout_id", timeout_id_o, to_id);
    pushes += int'(tx_wr_en_o);
    tos += int'(timeout_o);
    @(posedge sys_clk);
    l = 1'b0;
    if (x) begin
      l = ql[owner][0];
      void'(qd[owner].pop_front());
      void'(ql[owner].pop_front());
    end
    if (rst) begin
      owner = -1; lastg = N - 1; idle = 0; to_p = 0; to_id = 0;
    end else begin
      to_p = 0;
      if (owner < 0) begin
        if (|req_valid) begin
          pick = -1;
          for (int k = 1; k <= N; k++)
            if (pick < 0 && req_valid[(lastg + k) % N]) pick = (lastg + k) % N;
`ifdef UART_ARB_PRIO_EN
          if (req_valid[0]) pick = 0;
`endif
          owner = pick;
          idle = 0;
        end
      end else if (x) begin
        idle = 0;
        if (l) begin lastg = owner; owner = -1; end
      end else if (!req_valid[owner]) begin
        idle++;
        if (idle == TO) begin
          to_p = 1; to_id = owner; lastg = owner; owner = -1;
        end
      end
    end
  endtask

  initial begin
    full = 0;
    for (int i = 0; i < N; i++) stall[i] = 0;
    reset = 1; req_valid = '0; req_last = '0; req_data = '0; tx_full_i = 0;
    repeat (2) cycle(1);
    // two single-byte packets on req1 and req3
    push_pkt(1, 1, 8'h11);
    push_pkt(3, 1, 8'h33);
    pushes = 0;
    repeat (8) cycle(0);
    check("tp1_pushes", pushes, 2);
    // 3-byte packet on req0 must not be interleaved with req2
    push_pkt(0, 3, 8'hA0);
    push_pkt(2, 1, 8'h77);
    pushes = 0;
    repeat (10) cycle(0);
    check("tp2_pushes", pushes, 4);
    // full stall while granted: no push, no timeout
    push_pkt(1, 1, 8'h5A);
    full = 1;
    pushes = 0; tos = 0;
    repeat (12) cycle(0);
    check("tp3_no_push", pushes, 0);
    check("tp3_no_timeout", tos, 0);
    full = 0;
    repeat (3) cycle(0);
    check("tp3_push_after", pushes, 1);
    // non-last byte then silence on req1 -> watchdog
    qd[1].push_back(8'hC1);
    ql[1].push_back(1'b0);
    tos = 0;
    repeat (14) cycle(0);
    check("tp4_timeouts", tos, 1);
    check("tp4_id", timeout_id_o, 1);
    push_pkt(0, 1, 8'h40);
    push_pkt(2, 1, 8'h42);
    cycle(0);
    #1;
    check("tp4_next_is_2", grant_o, 4'b0100);
    repeat (6) cycle(0);
    // reset in the middle of a 4-byte packet from req3
    push_pkt(3, 4, 8'hD0);
    for (int k = 0; k < 20 && qd[3].size() > 2; k++) cycle(0);
    cycle(1);
    for (int i = 0; i < N; i++) begin qd[i].delete(); ql[i].delete(); end
    cycle(0);
    check("tp5_grant_cleared", grant_o, 0);
    for (int i = 0; i < N; i++) push_pkt(i, 1, W'(8'hE0 + i));
    cycle(0);
    #1;
    check("tp5_req0_first", grant_o, 4'b0001);
    repeat (12) cycle(0);
    // last_grant=0 with requests on 0,1,2
    push_pkt(0, 1, 8'hF0);
    repeat (4) cycle(0);
    push_pkt(0, 1, 8'hF1);
    push_pkt(1, 1, 8'hF2);
    push_pkt(2, 1, 8'hF3);
    cycle(0);
    #1;
`ifdef UART_ARB_PRIO_EN
    exp_g = 4'b0001;
`else
    exp_g = 4'b0010;
`endif
    check("tp6_grant", grant_o, exp_g);
    repeat (10) cycle(0);
    // randomized traffic, stalls, back-pressure and occasional reset
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (qd[i].size() == 0 && $urandom_range(0, 7) == 0)
          push_pkt(i, int'($urandom_range(1, 4)), W'($urandom));
        if ($urandom_range(0, 15) == 0) stall[i] = ~stall[i];
      end
      full = $urandom_range(0, 3) == 0;
      cycle($urandom_range(0, 499) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
